delay_meter: RTL and testbench

Measures the interval between two optical pulse edges in the synchronizing-pulse generator. This is the measurement counterpart of the delay generator: it counts clock cycles between a start-pulse rising edge and a stop-pulse rising edge and reports the count. Both pulse inputs come asynchronously from photodetectors. It serves for calibration and in-system checking of programmed inter-pulse delays.

---
 rtl/delay_meter.sv | 135 +++++++++++++
 tb/tb_delay_meter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_meter.sv
// Interval meter: counts clk_Meter cycles from a synchronized start-pulse rise to a stop-pulse rise.
// Pulse-to-FSM latency SYNC_STAGES+1 edges; result/valid visible after the DONE-entry edge; no backpressure.
module delay_meter #(
  parameter int WIDTH       = 35,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_Meter,
  input  logic             rst_Meter,
  input  logic             ME_arm,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic [WIDTH-1:0] timeout,
  output logic [WIDTH-1:0] ME_result,
  output logic             ME_valid,
  output logic             ME_timeout,
  output logic             ME_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COUNT,
    ST_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] start_sync;
  logic [SYNC_STAGES-1:0] stop_sync;
  logic                   start_prev;
  logic                   stop_prev;
  logic                   arm_q;
  logic                   start_edge;
  logic                   stop_edge;
  logic                   arm_rise;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       cnt_nxt;
  logic [WIDTH-1:0]       cnt_inc;
  logic [WIDTH-1:0]       eff_to;
  logic [WIDTH-1:0]       result_nxt;
  logic                   timeout_flag_nxt;

  // Both pulse paths are identical so the synchronizer delay cancels out of the interval.
  always_ff @(posedge clk_Meter) begin
    if (rst_Meter) begin
      start_sync <= '0;
      stop_sync  <= '0;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start_in};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop_in};
      start_prev <= start_sync[SYNC_STAGES-1];
      stop_prev  <= stop_sync[SYNC_STAGES-1];
      arm_q      <= ME_arm;
    end
  end

  assign start_edge = start_sync[SYNC_STAGES-1] & ~start_prev;
  assign stop_edge  = stop_sync[SYNC_STAGES-1] & ~stop_prev;
  assign arm_rise   = ME_arm & ~arm_q;

  assign eff_to  = (timeout == '0) ? '1 : timeout;
  // cnt stays below eff_to, so the increment cannot wrap.
  assign cnt_inc = cnt + ONE;

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    result_nxt       = ME_result;
    timeout_flag_nxt = ME_timeout;
    case (state)
      ST_IDLE: begin
        if (arm_rise) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!ME_arm) begin
          state_nxt = ST_IDLE;
        end else if (start_edge && stop_edge) begin
          state_nxt        = ST_DONE;
          result_nxt       = '0;
          timeout_flag_nxt = 1'b0;
        end else if (start_edge) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = '0;
        end
      end
      ST_COUNT: begin
        // A stop arriving on the timeout cycle is reported as a real measurement.
        if (!ME_arm) begin
          state_nxt = ST_IDLE;
        end else if (stop_edge) begin
          state_nxt        = ST_DONE;
          result_nxt       = cnt_inc;
          timeout_flag_nxt = 1'b0;
        end else if (cnt_inc >= eff_to) begin
          state_nxt        = ST_DONE;
          result_nxt       = eff_to;
          timeout_flag_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_Meter) begin
    if (rst_Meter) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ME_result  <= '0;
      ME_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ME_result  <= result_nxt;
      ME_timeout <= timeout_flag_nxt;
    end
  end

  assign ME_valid = (state == ST_DONE);
  assign ME_busy  = (state == ST_ARMED) || (state == ST_COUNT);

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: scoreboard of expected completions checked by a valid monitor.
module tb_delay_meter;

  localparam int W    = 35;
  localparam int SYNC = 2;

  typedef struct {
    logic [W-1:0] res;
    logic         to;
    int           cyc;
  } exp_t;

  logic         clk_Meter = 1'b0;
  logic         rst_Meter = 1'b0;
  logic         ME_arm    = 1'b0;
  logic         start_in  = 1'b0;
  logic         stop_in   = 1'b0;
  logic [W-1:0] timeout   = '0;
  logic [W-1:0] ME_result;
  logic         ME_valid;
  logic         ME_timeout;
  logic         ME_busy;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  delay_meter #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk_Meter (clk_Meter),
    .rst_Meter (rst_Meter),
    .ME_arm    (ME_arm),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .timeout   (timeout),
    .ME_result (ME_result),
    .ME_valid  (ME_valid),
    .ME_timeout(ME_timeout),
    .ME_busy   (ME_busy)
  );

  always #5 clk_Meter = ~clk_Meter;

  always @(posedge clk_Meter) cyc <= cyc + 1;

  // Completion monitor: every ME_valid cycle must match the head of the scoreboard.
  always @(negedge clk_Meter) begin
    if (ME_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_valid: ME_valid=1 at cycle %0d, required no completion", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks = checks + 3;
        if (ME_result !== mon_e.res) begin
          errors = errors + 1;
          $display("FAIL result: got %0d, expected %0d", ME_result, mon_e.res);
        end
        if (ME_timeout !== mon_e.to) begin
          errors = errors + 1;
          $display("FAIL timeout_flag: got %0b, expected %0b", ME_timeout, mon_e.to);
        end
        if (cyc !== mon_e.cyc) begin
          errors = errors + 1;
          $display("FAIL valid_cycle: got %0d, expected %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_Meter);
      #1;
    end
  endtask

  task automatic arm();
    ME_arm = 1'b0;
    step(1);
    ME_arm = 1'b1;
    step(1);
  endtask

  // Start rises at edge s0 (3-cycle pulse); stop rises d edges later, d<0 for no stop.
  task automatic measure(input int d, input int exp_off, input logic [W-1:0] exp_res,
                         input logic exp_to);
    int   s0;
    int   last;
    exp_t e;
    s0 = cyc + 1;
    e.res = exp_res;
    e.to  = exp_to;
    e.cyc = s0 + exp_off;
    sb.push_back(e);
    last = (d < 0) ? 3 : d + 3;
    for (int i = 0; i < last; i++) begin
      start_in = (i < 3);
      stop_in  = (d >= 0) && (i >= d) && (i < d + 3);
      step(1);
    end
    start_in = 1'b0;
    stop_in  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d completions outstanding after %0d cycles, expected 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_Meter = 1'b1;
    step(2);
    rst_Meter = 1'b0;
    checks = checks + 4;
    if (ME_result !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_result: got %0d, expected 0", ME_result);
    end
    if (ME_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_valid: got %0b, expected 0", ME_valid);
    end
    if (ME_timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_timeout: got %0b, expected 0", ME_timeout);
    end
    if (ME_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_busy: got %0b, expected 0", ME_busy);
    end
  endtask

  task automatic test_idle_edges();
    ME_arm  = 1'b0;
    timeout = W'(1000);
    start_in = 1'b1;
    step(3);
    start_in = 1'b0;
    step(2);
    stop_in = 1'b1;
    step(3);
    stop_in = 1'b0;
    step(10);
    checks = checks + 2;
    if (ME_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL idle_busy: got %0b, expected 0", ME_busy);
    end
    if (ME_result !== '0) begin
      errors = errors + 1;
      $display("FAIL idle_result: got %0d, expected 0", ME_result);
    end
  endtask

  task automatic test_basic();
    timeout = W'(1000);
    arm();
    checks = checks + 1;
    if (ME_busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL basic_busy_armed: got %0b, expected 1", ME_busy);
    end
    measure(250, 250 + SYNC, W'(250), 1'b0);
    wait_drain(20);
    checks = checks + 1;
    if (ME_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL basic_busy_after: got %0b, expected 0", ME_busy);
    end
  endtask

  task automatic test_abort();
    int s0;
    timeout = W'(1000);
    arm();
    s0 = cyc + 1;
    start_in = 1'b1;
    step(3);
    start_in = 1'b0;
    while (cyc < s0 + SYNC + 20) step(1);
    checks = checks + 1;
    if (ME_busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL abort_busy_counting: got %0b, expected 1", ME_busy);
    end
    ME_arm = 1'b0;
    step(1);
    checks = checks + 3;
    if (ME_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL abort_busy: got %0b, expected 0", ME_busy);
    end
    if (ME_result !== W'(250)) begin
      errors = errors + 1;
      $display("FAIL abort_result_held: got %0d, expected 250", ME_result);
    end
    if (ME_timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL abort_timeout_held: got %0b, expected 0", ME_timeout);
    end
    stop_in = 1'b1;
    step(3);
    stop_in = 1'b0;
    step(5);
  endtask

  task automatic test_timeout();
    timeout = W'(100);
    arm();
    measure(-1, 100 + SYNC, W'(100), 1'b1);
    wait_drain(150);
  endtask

  task automatic test_reset_mid();
    timeout = W'(1000);
    arm();
    start_in = 1'b1;
    step(3);
    start_in = 1'b0;
    step(12);
    checks = checks + 1;
    if (ME_busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rstmid_busy_before: got %0b, expected 1", ME_busy);
    end
    rst_Meter = 1'b1;
    ME_arm    = 1'b0;
    step(1);
    rst_Meter = 1'b0;
    checks = checks + 4;
    if (ME_result !== '0) begin
      errors = errors + 1;
      $display("FAIL rstmid_result: got %0d, expected 0", ME_result);
    end
    if (ME_timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rstmid_timeout: got %0b, expected 0", ME_timeout);
    end
    if (ME_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rstmid_valid: got %0b, expected 0", ME_valid);
    end
    if (ME_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rstmid_busy: got %0b, expected 0", ME_busy);
    end
    stop_in = 1'b1;
    step(3);
    stop_in = 1'b0;
    step(5);
  endtask

  task automatic test_boundary();
    timeout = W'(50);
    arm();
    measure(50, 50 + SYNC, W'(50), 1'b0);
    wait_drain(20);
    timeout = W'(1000);
    arm();
    measure(0, SYNC, W'(0), 1'b0);
    wait_drain(20);
  endtask

  task automatic test_stop_before_start();
    timeout = W'(1000);
    arm();
    stop_in = 1'b1;
    step(3);
    stop_in = 1'b0;
    step(6);
    checks = checks + 1;
    if (ME_busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL early_stop_busy: got %0b, expected 1", ME_busy);
    end
    measure(10, 10 + SYNC, W'(10), 1'b0);
    wait_drain(20);
  endtask

  task automatic test_arm_held();
    timeout = W'(1000);
    arm();
    measure(5, 5 + SYNC, W'(5), 1'b0);
    wait_drain(20);
    start_in = 1'b1;
    step(3);
    start_in = 1'b0;
    step(2);
    stop_in = 1'b1;
    step(3);
    stop_in = 1'b0;
    step(10);
    checks = checks + 2;
    if (ME_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL held_arm_busy: got %0b, expected 0", ME_busy);
    end
    if (ME_result !== W'(5)) begin
      errors = errors + 1;
      $display("FAIL held_arm_result: got %0d, expected 5", ME_result);
    end
    ME_arm = 1'b0;
    step(2);
  endtask

  initial begin
    step(1);
    test_reset();
    test_idle_edges();
    test_basic();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_boundary();
    test_stop_before_start();
    test_arm_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
